// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Divides clk down to a tenth-second tick, counts elapsed time in BCD
//   (minutes, tens of seconds, ones of seconds, tenths) and runs the
//   start/pause/clear control with a lap-hold freeze of the digit outputs.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   start_stop     in   single-cycle pulse, toggles run/pause
//   clear          in   single-cycle pulse, zeroes count and returns to idle
//   lap            in   single-cycle pulse, toggles lap-hold
//   Minutes        out  BCD 0-9
//   Tens_Seconds   out  BCD 0-5
//   Ones_Seconds   out  BCD 0-9
//   Tenths_Seconds out  BCD 0-9
//   running        out  high while counting
//   lap_held       out  high while digit outputs are frozen
//   overflow       out  sticky, set on the 9:59.9 -> 0:00.0 wrap
module stopwatch_counter #(
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned PRESCALE_W = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] Minutes,
  output logic [3:0] Tens_Seconds,
  output logic [3:0] Ones_Seconds,
  output logic [3:0] Tenths_Seconds,
  output logic       running,
  output logic       lap_held,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            min_q, min_d, tens_q, tens_d, ones_q, ones_d, tenth_q, tenth_d;
  logic [3:0]            min_out_q, min_out_d, tens_out_q, tens_out_d;
  logic [3:0]            ones_out_q, ones_out_d, tenth_out_q, tenth_out_d;
  logic                  running_q, running_d;
  logic                  lap_held_q, lap_held_d;
  logic                  overflow_q, overflow_d;
  logic                  tick_s;
  logic                  wrap_s;

  // Control state and prescaler; the prescaler only moves while running so a
  // pause resumes mid-tenth.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_s  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      if (state_q == ST_RUN) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_s  = 1'b1;
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end else begin
        presc_d = presc_q;
      end
      if (start_stop) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // BCD digit chain; every carry ripples within the same edge.
  always_comb begin
    tenth_d = tenth_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    min_d   = min_q;
    wrap_s  = 1'b0;
    if (clear) begin
      tenth_d = 4'd0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      min_d   = 4'd0;
    end else if (tick_s) begin
      if (tenth_q >= 4'd9) begin
        tenth_d = 4'd0;
        if (ones_q >= 4'd9) begin
          ones_d = 4'd0;
          if (tens_q >= 4'd5) begin
            tens_d = 4'd0;
            if (min_q >= 4'd9) begin
              min_d  = 4'd0;
              wrap_s = 1'b1;
            end else begin
              min_d = min_q + 4'd1;
            end
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        tenth_d = tenth_q + 4'd1;
      end
    end else begin
      tenth_d = tenth_q;
    end
  end

  // Lap-hold, status flags and the output digit registers. The output
  // registers load next-state digits so unheld outputs have no extra latency,
  // and a snapshot coinciding with a tick captures the post-tick value.
  always_comb begin
    lap_held_d  = lap_held_q;
    overflow_d  = overflow_q;
    running_d   = (state_d == ST_RUN);
    min_out_d   = min_d;
    tens_out_d  = tens_d;
    ones_out_d  = ones_d;
    tenth_out_d = tenth_d;
    if (clear) begin
      lap_held_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (lap) begin
        if (lap_held_q) begin
          lap_held_d = 1'b0;
        end else if (state_q == ST_RUN) begin
          lap_held_d = 1'b1;
        end else begin
          lap_held_d = 1'b0;
        end
      end else begin
        lap_held_d = lap_held_q;
      end
      if (wrap_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
    // Frozen only while the hold was already in place before this edge.
    if (lap_held_d && lap_held_q) begin
      min_out_d   = min_out_q;
      tens_out_d  = tens_out_q;
      ones_out_d  = ones_out_q;
      tenth_out_d = tenth_out_q;
    end else begin
      min_out_d   = min_d;
      tens_out_d  = tens_d;
      ones_out_d  = ones_d;
      tenth_out_d = tenth_d;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      tenth_q     <= 4'd0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      min_q       <= 4'd0;
      tenth_out_q <= 4'd0;
      ones_out_q  <= 4'd0;
      tens_out_q  <= 4'd0;
      min_out_q   <= 4'd0;
      running_q   <= 1'b0;
      lap_held_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tenth_q     <= tenth_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      min_q       <= min_d;
      tenth_out_q <= tenth_out_d;
      ones_out_q  <= ones_out_d;
      tens_out_q  <= tens_out_d;
      min_out_q   <= min_out_d;
      running_q   <= running_d;
      lap_held_q  <= lap_held_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Minutes        = min_out_q;
  assign Tens_Seconds   = tens_out_q;
  assign Ones_Seconds   = ones_out_q;
  assign Tenths_Seconds = tenth_out_q;
  assign running        = running_q;
  assign lap_held       = lap_held_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Directed and random stimulus for stopwatch_counter with TICK_DIV=4,
//   compared every cycle against an elapsed-tenths reference model.
module tb_stopwatch_counter;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
  logic       running, lap_held, overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed time as a plain count of tenths.
  int m_t     = 0;
  int m_pc    = 0;
  bit m_run   = 1'b0;
  bit m_held  = 1'b0;
  int m_snap  = 0;
  bit m_ovf   = 1'b0;

  stopwatch_counter #(.TICK_DIV(TICK), .PRESCALE_W(3)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .Minutes(Minutes), .Tens_Seconds(Tens_Seconds), .Ones_Seconds(Ones_Seconds),
    .Tenths_Seconds(Tenths_Seconds), .running(running), .lap_held(lap_held),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input bit ss, input bit clr, input bit lp, input bit rst);
    bit was_run;
    bit tk;
    if (rst || clr) begin
      m_t = 0; m_pc = 0; m_run = 1'b0; m_held = 1'b0; m_snap = 0; m_ovf = 1'b0;
    end else begin
      was_run = m_run;
      tk = 1'b0;
      if (was_run) begin
        if (m_pc == TICK - 1) begin m_pc = 0; tk = 1'b1; end
        else m_pc = m_pc + 1;
      end
      if (tk) begin
        m_t = m_t + 1;
        if (m_t == 6000) begin m_t = 0; m_ovf = 1'b1; end
      end
      if (ss) m_run = !m_run;
      if (lp) begin
        if (m_held) m_held = 1'b0;
        else if (was_run) begin m_held = 1'b1; m_snap = m_t; end
      end
    end
  endtask

  task automatic compare_all();
    int shown;
    shown = m_held ? m_snap : m_t;
    check("minutes",  int'(Minutes),        shown / 600);
    check("tens_sec", int'(Tens_Seconds),   (shown / 100) % 6);
    check("ones_sec", int'(Ones_Seconds),   (shown / 10) % 10);
    check("tenths",   int'(Tenths_Seconds), shown % 10);
    check("running",  int'(running),  int'(m_run));
    check("lap_held", int'(lap_held), int'(m_held));
    check("overflow", int'(overflow), int'(m_ovf));
    check("bcd_valid", int'(Minutes <= 4'd9 && Tens_Seconds <= 4'd5 &&
                            Ones_Seconds <= 4'd9 && Tenths_Seconds <= 4'd9), 1);
  endtask

  task automatic step(input bit ss, input bit clr, input bit lp, input bit rst);
    start_stop = ss; clear = clr; lap = lp; reset = rst;
    @(posedge clk);
    model_edge(ss, clr, lp, rst);
    #1;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; reset = 1'b0;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance until the model count reaches target, bounded by a cycle budget.
  task automatic run_to(input int target, input int budget);
    int n;
    n = 0;
    while (m_t != target && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("run_to_reached", m_t, target);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // First tenth at E0+4, second at E0+8
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);
    check("pre_first_tenth", int'(Tenths_Seconds), 0);
    idle_cycles(1);
    check("first_tenth", int'(Tenths_Seconds), 1);
    idle_cycles(4);
    check("second_tenth", int'(Tenths_Seconds), 2);

    // Pause at E6, hold 20 cycles, resume: second tenth after 2 run cycles
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(20);
    check("paused_tenths", int'(Tenths_Seconds), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    check("resume_not_yet", int'(Tenths_Seconds), 1);
    idle_cycles(1);
    check("resume_tick", int'(Tenths_Seconds), 2);

    // Lap at 0:01.3, count continues underneath, second lap releases
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_to(13, 200);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(30);
    check("lap_frozen_tenths", int'(Tenths_Seconds), 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(3);

    // Lap ignored while paused
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_ignored_paused", int'(lap_held), 0);

    // Priority: clear with start_stop from PAUSE at 0:03.2
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_to(32, 400);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("prio_running", int'(running), 0);
    idle_cycles(6);

    // Full run through 0:59.9 -> 1:00.0 and up to the 9:59.9 wrap
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_to(599, 3000);
    idle_cycles(TICK);
    check("carry_min", int'(Minutes), 1);
    run_to(5999, 30000);
    idle_cycles(TICK);
    check("wrap_overflow", int'(overflow), 1);
    check("wrap_running", int'(running), 1);
    idle_cycles(40);
    check("overflow_sticky", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_overflow", int'(overflow), 0);

    // Random pulses
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 4, $urandom_range(0, 999) < 5,
           $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
